// File: rtl/microwave_pkg.sv
// Shared constants and types for the microwave keypad entry datapath.
package microwave_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;

  // Debounce FSM encoding; the values are fixed so waveforms and logs line up across blocks.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_e;

  // True when a nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [BCD_W-1:0] value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/keypad_digit_buffer_if.sv
// Signal bundle between the keypad encoder side and the digit buffer.
interface keypad_digit_buffer_if;
  import microwave_pkg::*;

  logic [BCD_W-1:0]            bcd_in;
  logic                        loadn;
  logic                        clearn;
  logic                        lock;
  logic                        enablen;
  logic [NUM_DIGITS*BCD_W-1:0] digits;
  logic [2:0]                  digit_count;
  logic                        full;
  logic                        new_digit;

  // Master drives the key inputs and observes the buffer.
  modport master (
    output bcd_in, loadn, clearn, lock,
    input  enablen, digits, digit_count, full, new_digit
  );

  // Slave is the digit buffer itself.
  modport slave (
    input  bcd_in, loadn, clearn, lock,
    output enablen, digits, digit_count, full, new_digit
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus debounce FSM for the encoder strobe.
// Emits a single-cycle press_accept_o on the edge a press is accepted,
// together with the synchronized digit to capture on that same edge.
module sync_debounce
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadn_i,
  input  logic [BCD_W-1:0] bcd_i,
  output logic             press_accept_o,
  output logic [BCD_W-1:0] bcd_s_o
);

  // The counter holds samples already seen, so the final sample is the one
  // arriving while the counter sits at DEBOUNCE_CYCLES-1.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         INSTANT  = (DEBOUNCE_CYCLES == 1);

  logic             loadn_meta_q;
  logic             loadn_s_q;
  logic [BCD_W-1:0] bcd_meta_q;
  logic [BCD_W-1:0] bcd_s_q;

  debounce_state_e  state_q;
  debounce_state_e  state_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             cnt_done;

  assign cnt_done = (cnt_q >= CNT_LAST);

  // Bring the asynchronous strobe and digit into the clock domain; idle values on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loadn_meta_q <= 1'b1;
      loadn_s_q    <= 1'b1;
      bcd_meta_q   <= '0;
      bcd_s_q      <= '0;
    end else begin
      loadn_meta_q <= loadn_i;
      loadn_s_q    <= loadn_meta_q;
      bcd_meta_q   <= bcd_i;
      bcd_s_q      <= bcd_meta_q;
    end
  end

  // State and sample counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: require a run of identical samples to move between idle and held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!loadn_s_q) begin
          if (INSTANT) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      PRESS_WAIT: begin
        if (loadn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (loadn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 8'd1;
        end
      end
      RELEASE_WAIT: begin
        if (!loadn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: the accept pulse marks the transition into HELD from a press.
  always_comb begin
    press_accept_o = 1'b0;
    if (!loadn_s_q) begin
      if (state_q == IDLE && INSTANT) begin
        press_accept_o = 1'b1;
      end else if (state_q == PRESS_WAIT && cnt_done) begin
        press_accept_o = 1'b1;
      end
    end
  end

  assign bcd_s_o = bcd_s_q;

endmodule

// File: rtl/keypad_digit_buffer.sv
// Four-digit MM:SS entry buffer fed by debounced keypad presses.
// Shifts each accepted digit in from the right, honours clear and lock,
// and tells the encoder to stop while locked or full.
module keypad_digit_buffer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypad_digit_buffer_if.slave bus
);

  localparam logic [2:0] COUNT_FULL = 3'(NUM_DIGITS);

  logic                        press_accept;
  logic [BCD_W-1:0]            bcd_s;

  logic [NUM_DIGITS*BCD_W-1:0] digits_q;
  logic [NUM_DIGITS*BCD_W-1:0] digits_d;
  logic [2:0]                  count_q;
  logic [2:0]                  count_d;
  logic                        new_digit_q;
  logic                        new_digit_d;
  logic                        enablen_q;
  logic                        enablen_d;

  logic                        full_now;
  logic                        clear_req;
  logic                        accept_ok;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk            (clk),
    .rst_n          (rst_n),
    .loadn_i        (bus.loadn),
    .bcd_i          (bus.bcd_in),
    .press_accept_o (press_accept),
    .bcd_s_o        (bcd_s)
  );

  assign full_now  = (count_q == COUNT_FULL);
  assign clear_req = !bus.clearn && !bus.lock;
  assign accept_ok = press_accept && is_bcd(bcd_s) && !bus.lock && !full_now;

  // Buffer update: clear wins over a simultaneous accept; invalid, locked or overflow presses are dropped.
  always_comb begin
    digits_d    = digits_q;
    count_d     = count_q;
    new_digit_d = 1'b0;
    if (clear_req) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept_ok) begin
      digits_d    = {digits_q[(NUM_DIGITS-1)*BCD_W-1:0], bcd_s};
      count_d     = count_q + 3'd1;
      new_digit_d = 1'b1;
    end
    enablen_d = bus.lock | (count_d == COUNT_FULL);
  end

  // Buffer, count, pulse and encoder-enable registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_q    <= '0;
      count_q     <= '0;
      new_digit_q <= 1'b0;
      enablen_q   <= 1'b1;
    end else begin
      digits_q    <= digits_d;
      count_q     <= count_d;
      new_digit_q <= new_digit_d;
      enablen_q   <= enablen_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_count = count_q;
  assign bus.full        = full_now;
  assign bus.new_digit   = new_digit_q;
  assign bus.enablen     = enablen_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Directed bench for keypad_digit_buffer at the default debounce length.
module tb_keypad_digit_buffer;

  localparam int D = 4;

  logic clk;
  logic rst_n;

  keypad_digit_buffer_if bus ();

  keypad_digit_buffer #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  bcd;
    logic [15:0] expDigits;
    logic [2:0]  expCount;
    logic        expFull;
    logic        expEnablen;
    int          expPulses;
  } press_vec_t;

  press_vec_t vecs [6];

  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount  = 0;
  logic fullAtPulse;
  logic enAtPulse;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count new_digit pulses mid-cycle and remember full/enablen seen alongside each one.
  always @(negedge clk) begin
    if (bus.new_digit === 1'b1) begin
      pulseCount  = pulseCount + 1;
      fullAtPulse = bus.full;
      enAtPulse   = bus.enablen;
    end
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_digits"},  32'(bus.digits),      32'h0);
    checkOutput({tag, "_count"},   32'(bus.digit_count), 32'h0);
    checkOutput({tag, "_full"},    32'(bus.full),        32'h0);
    checkOutput({tag, "_new"},     32'(bus.new_digit),   32'h0);
    checkOutput({tag, "_enablen"}, 32'(bus.enablen),     32'h1);
  endtask

  // One complete press: hold, release, then wait out the release debounce.
  task automatic applyStimulus(input logic [3:0] bcd, input int holdCycles, output int pulses);
    int start;
    start       = pulseCount;
    bus.bcd_in  = bcd;
    bus.loadn   = 1'b0;
    tick(holdCycles);
    bus.loadn   = 1'b1;
    tick(2 * D + 6);
    pulses      = pulseCount - start;
  endtask

  task automatic clearBuffer();
    bus.clearn = 1'b0;
    tick(1);
    bus.clearn = 1'b1;
  endtask

  initial begin
    int p;
    int start;

    vecs[0] = '{4'hA, 16'h0000, 3'd0, 1'b0, 1'b0, 0};
    vecs[1] = '{4'h1, 16'h0001, 3'd1, 1'b0, 1'b0, 1};
    vecs[2] = '{4'h2, 16'h0012, 3'd2, 1'b0, 1'b0, 1};
    vecs[3] = '{4'h3, 16'h0123, 3'd3, 1'b0, 1'b0, 1};
    vecs[4] = '{4'h0, 16'h1230, 3'd4, 1'b1, 1'b1, 1};
    vecs[5] = '{4'h7, 16'h1230, 3'd4, 1'b1, 1'b1, 0};

    bus.bcd_in = 4'h0;
    bus.loadn  = 1'b1;
    bus.clearn = 1'b1;
    bus.lock   = 1'b0;
    rst_n      = 1'b0;
    tick(3);
    checkReset("reset");
    rst_n = 1'b1;
    tick(2);

    // Single press of 3: digit appears exactly on edge 5.
    start      = pulseCount;
    bus.bcd_in = 4'h3;
    bus.loadn  = 1'b0;
    tick(5);
    checkOutput("single_e4_new",    32'(bus.new_digit),   32'h0);
    checkOutput("single_e4_digits", 32'(bus.digits),      32'h0);
    tick(1);
    checkOutput("single_e5_new",    32'(bus.new_digit),   32'h1);
    checkOutput("single_e5_digits", 32'(bus.digits),      32'h0003);
    checkOutput("single_e5_count",  32'(bus.digit_count), 32'h1);
    tick(1);
    checkOutput("single_e6_new",    32'(bus.new_digit),   32'h0);
    tick(13);
    bus.loadn = 1'b1;
    tick(14);
    checkOutput("single_pulses",    32'(pulseCount - start), 32'h1);

    clearBuffer();
    checkOutput("clear_digits", 32'(bus.digits),      32'h0);
    checkOutput("clear_count",  32'(bus.digit_count), 32'h0);

    // Invalid digit, then 1,2,3,0 to fill, then a fifth press that must be ignored.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].bcd, 12, p);
      checkOutput($sformatf("vec%0d_digits", i),  32'(bus.digits),      32'(vecs[i].expDigits));
      checkOutput($sformatf("vec%0d_count", i),   32'(bus.digit_count), 32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d_full", i),    32'(bus.full),        32'(vecs[i].expFull));
      checkOutput($sformatf("vec%0d_enablen", i), 32'(bus.enablen),     32'(vecs[i].expEnablen));
      checkOutput($sformatf("vec%0d_pulses", i),  32'(p),               32'(vecs[i].expPulses));
      if (p == 1) begin
        checkOutput($sformatf("vec%0d_full_at_pulse", i), 32'(fullAtPulse), 32'(vecs[i].expFull));
        checkOutput($sformatf("vec%0d_en_at_pulse", i),   32'(enAtPulse),   32'(vecs[i].expEnablen));
      end
    end

    // Bounce: three 2-low/2-high cycles, then a steady press of 6.
    clearBuffer();
    start      = pulseCount;
    bus.bcd_in = 4'h6;
    for (int k = 0; k < 3; k++) begin
      bus.loadn = 1'b0;
      tick(2);
      bus.loadn = 1'b1;
      tick(2);
    end
    checkOutput("bounce_no_pulse", 32'(pulseCount - start), 32'h0);
    bus.loadn = 1'b0;
    tick(5);
    checkOutput("bounce_e4_new",    32'(bus.new_digit), 32'h0);
    tick(1);
    checkOutput("bounce_e5_new",    32'(bus.new_digit), 32'h1);
    checkOutput("bounce_e5_digits", 32'(bus.digits),    32'h0006);
    tick(10);
    bus.loadn = 1'b1;
    tick(14);
    checkOutput("bounce_pulses", 32'(pulseCount - start), 32'h1);

    // Clear landing on the accept edge of a press of 5.
    start      = pulseCount;
    bus.bcd_in = 4'h5;
    bus.loadn  = 1'b0;
    tick(5);
    bus.clearn = 1'b0;
    tick(1);
    checkOutput("clracc_digits", 32'(bus.digits),      32'h0);
    checkOutput("clracc_count",  32'(bus.digit_count), 32'h0);
    checkOutput("clracc_new",    32'(bus.new_digit),   32'h0);
    bus.clearn = 1'b1;
    tick(10);
    bus.loadn = 1'b1;
    tick(14);
    checkOutput("clracc_pulses",     32'(pulseCount - start), 32'h0);
    checkOutput("clracc_end_digits", 32'(bus.digits),         32'h0);

    // Lock: buffer frozen through a press and a clear, nothing leaks out on unlock.
    applyStimulus(4'h4, 12, p);
    applyStimulus(4'h2, 12, p);
    checkOutput("lock_pre_digits", 32'(bus.digits), 32'h0042);
    start    = pulseCount;
    bus.lock = 1'b1;
    tick(1);
    checkOutput("lock_enablen", 32'(bus.enablen), 32'h1);
    applyStimulus(4'h9, 12, p);
    checkOutput("lock_press_pulses", 32'(p),          32'h0);
    checkOutput("lock_press_digits", 32'(bus.digits), 32'h0042);
    clearBuffer();
    checkOutput("lock_clear_digits",  32'(bus.digits),      32'h0042);
    checkOutput("lock_clear_count",   32'(bus.digit_count), 32'h2);
    checkOutput("lock_clear_enablen", 32'(bus.enablen),     32'h1);
    bus.lock = 1'b0;
    tick(1);
    checkOutput("unlock_enablen", 32'(bus.enablen), 32'h0);
    tick(10);
    checkOutput("unlock_digits", 32'(bus.digits),         32'h0042);
    checkOutput("unlock_count",  32'(bus.digit_count),    32'h2);
    checkOutput("unlock_pulses", 32'(pulseCount - start), 32'h0);

    // Reset during PRESS_WAIT with the key of 8 held throughout.
    bus.bcd_in = 4'h8;
    bus.loadn  = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    checkReset("midrst");
    start = pulseCount;
    rst_n = 1'b1;
    tick(5);
    checkOutput("midrst_e4_new",    32'(bus.new_digit),   32'h0);
    tick(1);
    checkOutput("midrst_e5_new",    32'(bus.new_digit),   32'h1);
    checkOutput("midrst_e5_digits", 32'(bus.digits),      32'h0008);
    checkOutput("midrst_e5_count",  32'(bus.digit_count), 32'h1);
    tick(8);
    bus.loadn = 1'b1;
    tick(14);
    checkOutput("midrst_pulses", 32'(pulseCount - start), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/keypad_digit_buffer.md
# keypad_digit_buffer

Sequential stage directly downstream of the keypad priority encoder in the microwave datapath. Synchronizes and debounces the encoder's active-low `loadn` strobe, captures one BCD digit per key press, and shifts it into a 4-digit MM:SS entry buffer. It drives `enablen` back to the encoder to block further entry while the timer runs or the buffer is full.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized samples required to accept a press or a release. Legal range is 1..255.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `bcd_in`  in  4: BCD digit from the encoder. Asynchronous to `clk`.
- `loadn`  in  1: encoder key-valid strobe, active low. Asynchronous to `clk`.
- `clearn`  in  1: clear-key request, active low. Level-sensitive and already synchronous.
- `lock`  in  1: high while the cook timer is running. It freezes the buffer.
- `enablen`  out  1: encoder enable, active low. Registered.
- `digits`  out  16: buffer contents, `[15:12]` = min tens, `[11:8]` = min units, `[7:4]` = sec tens, `[3:0]` = sec units.
- `digit_count`  out  3: number of digits entered, 0..4.
- `full`  out  1: high when `digit_count == 4`.
- `new_digit`  out  1: one-cycle pulse on the cycle `digits` updates.

## Operation
- **Synchronizer:** `loadn` and `bcd_in` each pass through a 2-flop synchronizer. The synchronized versions are `loadn_s` and `bcd_s`.
- **Debounce FSM** (states `IDLE`, `PRESS_WAIT`, `HELD`, `RELEASE_WAIT`), with an 8-bit counter `cnt`:
  - `IDLE`: if `loadn_s == 0`, set `cnt = 1` and go to `PRESS_WAIT`. If `DEBOUNCE_CYCLES == 1`, accept immediately instead.
  - `PRESS_WAIT`: if `loadn_s == 1`, go to `IDLE`.
    - Otherwise increment `cnt`.
    - When `cnt` reaches `DEBOUNCE_CYCLES`, accept the press and go to `HELD`.
  - `HELD`: if `loadn_s == 1`, set `cnt = 1` and go to `RELEASE_WAIT`. A held key yields exactly one digit.
  - `RELEASE_WAIT`: if `loadn_s == 0`, go to `HELD`.
    - Otherwise increment `cnt`.
    - When `cnt` reaches `DEBOUNCE_CYCLES`, go to `IDLE`.
- **Accept:** on an accepted press, `bcd_s` is sampled on that same edge.
  - If `bcd_s <= 9`, not `lock`, and not `full`: `digits <= {digits[11:0], bcd_s}`, `digit_count` increments, and `new_digit` is 1 next cycle.
  - Otherwise the press is consumed (FSM still goes to `HELD`), the buffer is unchanged, and there is no pulse.
- **Clear:** `clearn == 0` with `lock == 0` sets `digits = 0` and `digit_count = 0`. The FSM is not affected.
  - Clear beats an accept on the same edge: the result is 0 digits and no `new_digit`.
  - `clearn` while `lock == 1` is ignored.
- **Lock:** while `lock == 1`, the buffer holds its value and the FSM keeps running. This prevents a phantom digit on unlock.
- **Full:** the 5th and later presses are ignored. `digits` never wraps; only clear empties it.
- **Encoder enable:** `enablen <= lock | full_next`, registered, where `full_next` is the value `full` takes on the same edge. A full buffer therefore stops the encoder.
- **Reset** (`rst_n == 0` at an edge): outputs take these values:
  - `digits = 0`, `digit_count = 0`, `full = 0`, `new_digit = 0`, `enablen = 1`.
  - FSM goes to `IDLE` with `cnt = 0`, and the synchronizers load 1 for `loadn`, 0 for `bcd`.
  - Reset mid-press: after release the FSM is in `IDLE`. A key still held when reset lifts produces one digit after a full debounce.

## Timing
- Define edge 0 as the first rising edge on which raw `loadn` is stably low.
- `loadn_s` is low from edge 1.
- The press is accepted at edge `1 + DEBOUNCE_CYCLES` (edge 5 at the default).
- `digits`, `digit_count` and `full` are valid after that edge, and `new_digit` is high for that one cycle.
- `enablen` changes in the same cycle as `full` or one cycle after `lock` changes.
- `bcd_in` must be stable from edge 0 through acceptance. The encoder guarantees this while the key is held.
- Minimum press-to-press interval is `2 * DEBOUNCE_CYCLES + 2` cycles.

## Structure
- **Shared package `microwave_pkg`:**
  - `BCD_W = 4` and `BCD_MAX = 4'd9`.
  - `NUM_DIGITS = 4`.
  - Debounce state encoding: `IDLE = 2'd0`, `PRESS_WAIT = 2'd1`, `HELD = 2'd2`, `RELEASE_WAIT = 2'd3`.
- **Sub-module `sync_debounce`:** holds the 2-flop synchronizer, FSM and counter.
  - Parameterized by `DEBOUNCE_CYCLES`.
  - Outputs a one-cycle `press_accept` pulse plus `bcd_s`.
- **Top module:** holds the shift buffer, count, clear/lock logic and `enablen` register.

## Test plan
- **Single press:** reset, then hold `loadn=0`, `bcd_in=4'd3` for 20 cycles, then release.
  - Required: exactly one `new_digit` at edge 5 after `loadn` falls, and `digits = 16'h0003`, `digit_count = 1`.
- **Sequence 1,2,3,0:** four clean presses.
  - Required: `digits = 16'h1230`, `full = 1`, `enablen = 1` on the same cycle as `full`.
  - A 5th press of 7 leaves `16'h1230` and gives no pulse.
- **Bounce:** `loadn` toggles low/high every 2 cycles for 12 cycles, then is held low.
  - Required: no digit during the bouncing; one digit 5 edges after the steady low begins.
- **Clear vs accept:** assert `clearn=0` on the accept edge of a press of 5.
  - Required: `digits = 0`, `digit_count = 0`, `new_digit = 0`, and the FSM reaches `HELD` (no digit on release).
- **Lock:** with 2 digits entered, set `lock=1`, press 9, pulse `clearn`, then set `lock=0`.
  - Required: `digits` is unchanged throughout, `enablen = 1` while locked, and no digit appears after unlock.
- **Reset mid-press:** assert `rst_n=0` during `PRESS_WAIT` with the key held.
  - Required: all outputs take their reset values.
  - After `rst_n=1` with the key still held, exactly one digit is accepted `1 + DEBOUNCE_CYCLES` edges later.
